// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, clock deglitch filter, frame FSM with
// watchdog, parity/stop checking and a show-ahead FIFO with a valid/ready read port.
module ps2_rx_fifo #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8,
    parameter int AW          = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [7:0]    rd_data,
    output logic          rd_err,
    output logic [AW:0]   fifo_count,
    output logic          overflow,
    input  logic          clr_ovf,
    output logic          busy,
    output logic          timeout_p
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);

    localparam logic [FW-1:0] FCNT_ONE  = FW'(1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);
    localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Input synchronisers and deglitch filter
    logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic          filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;

    // Frame FSM
    state_t        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [9:0]    shreg_q, shreg_d;
    logic          timeout_p_q, timeout_p_d;
    logic          busy_q, busy_d;

    // FIFO
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d, remain;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_err_q, rd_err_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;

    logic          sample_ev, bit_in, in_check, full, push, pop, frame_err;
    logic [8:0]    push_word;

    always_comb begin
        fcnt_d = '0;
        filt_d = filt_q;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCNT_LAST) begin
                filt_d = ~filt_q;
            end else begin
                fcnt_d = fcnt_q + FCNT_ONE;
            end
        end
    end

    // Falling edge is detected one cycle after the filter toggles.
    assign sample_ev = filt_prev_q & ~filt_q;
    assign bit_in    = data_s2_q;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        timer_d     = timer_q;
        shreg_d     = shreg_q;
        timeout_p_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample_ev && !bit_in) begin
                    state_d  = SHIFT;
                    bitcnt_d = 4'd0;
                    timer_d  = '0;
                end
            end
            SHIFT: begin
                if (sample_ev) begin
                    shreg_d  = {bit_in, shreg_q[9:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    timer_d  = '0;
                    if (bitcnt_q == 4'd9) begin
                        state_d = CHECK;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d     = IDLE;
                    timeout_p_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Odd parity over data+parity; stop bit must be 1.
    assign frame_err = ~(^shreg_q[8:0]) | ~shreg_q[9];
    assign push_word = {frame_err, shreg_q[7:0]};
    assign in_check  = (state_q == CHECK);
    assign full      = (count_q == CNT_FULL);
    assign push      = in_check & ~full;
    assign pop       = rd_valid_q & rd_ready;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        remain     = pop  ? count_q - CNT_ONE  : count_q;
        count_d    = push ? remain + CNT_ONE   : remain;
        rd_valid_d = (count_d != '0);
        overflow_d = overflow_q;
        if (clr_ovf) begin
            overflow_d = 1'b0;
        end
        if (in_check && full) begin
            overflow_d = 1'b1;
        end
        // Head register: the pushed word when it lands in an empty FIFO,
        // otherwise the stored entry at the new read pointer; hold when empty.
        rd_data_d = rd_data_q;
        rd_err_d  = rd_err_q;
        if (count_d != '0) begin
            if (remain == '0) begin
                rd_data_d = push_word[7:0];
                rd_err_d  = push_word[8];
            end else begin
                rd_data_d = mem[rd_ptr_d][7:0];
                rd_err_d  = mem[rd_ptr_d][8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            data_s1_q   <= 1'b1;
            data_s2_q   <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= IDLE;
            bitcnt_q    <= 4'd0;
            timer_q     <= '0;
            shreg_q     <= '0;
            timeout_p_q <= 1'b0;
            busy_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= 8'h00;
            rd_err_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            data_s1_q   <= ps2_data;
            data_s2_q   <= data_s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            timer_q     <= timer_d;
            shreg_q     <= shreg_d;
            timeout_p_q <= timeout_p_d;
            busy_q      <= busy_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_err_q    <= rd_err_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_err     = rd_err_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;
    assign timeout_p  = timeout_p_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: table of single frames plus hand-written sequences
// for glitch rejection, watchdog, FIFO overflow and mid-frame reset.
module tb_ps2_rx_fifo;

    localparam int FL    = 8;
    localparam int TO    = 1000;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int H     = 40;
    localparam int LAT   = 2 + FL + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic          rd_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          rd_valid, rd_err, overflow, busy, timeout_p;
    logic [7:0]    rd_data;
    logic [AW:0]   fifo_count;

    int errors = 0;
    int checks = 0;

    ps2_rx_fifo #(
        .FILTER_LEN (FL),
        .TIMEOUT_CYC(TO),
        .FIFO_DEPTH (DEPTH),
        .AW         (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_err    (rd_err),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .busy      (busy),
        .timeout_p (timeout_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pflip;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One PS/2 bit; lat = ticks after the falling edge until fifo_count changes (0 if never).
    task automatic ps2_bit(input logic b, output int lat);
        logic [AW:0] cnt0;
        ps2_data = b;
        repeat (H) tick();
        cnt0 = fifo_count;
        ps2_clk = 1'b0;
        lat = 0;
        for (int i = 1; i <= H; i++) begin
            tick();
            if (lat == 0 && fifo_count != cnt0) lat = i;
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop,
                              output int lat);
        int l;
        ps2_bit(1'b0, l);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], l);
        ps2_bit((~^d) ^ pflip, l);
        ps2_bit(stop, lat);
        ps2_data = 1'b1;
        repeat (H) tick();
    endtask

    task automatic pop();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int pulses;
        int at_tick;
        logic seen_busy;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 8'h1C, 1'b1};
        vecs[2] = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b1};
        vecs[3] = '{8'hF0, 1'b0, 1'b1, 8'hF0, 1'b0};
        vecs[4] = '{8'hAA, 1'b0, 1'b1, 8'hAA, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
        vecs[7] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0};

        repeat (3) tick();
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_fifo_count", fifo_count, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overflow", overflow, 0);
        reset = 1'b0;
        repeat (5) tick();

        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].data, vecs[v].pflip, vecs[v].stop, lat);
            $display("frame %0d: sent %02h pflip=%0b stop=%0b -> rd_data=%02h rd_err=%0b lat=%0d",
                     v, vecs[v].data, vecs[v].pflip, vecs[v].stop, rd_data, rd_err, lat);
            chk($sformatf("v%0d_latency", v), lat, LAT);
            chk($sformatf("v%0d_rd_valid", v), rd_valid, 1);
            chk($sformatf("v%0d_rd_data", v), rd_data, vecs[v].exp_data);
            chk($sformatf("v%0d_rd_err", v), rd_err, vecs[v].exp_err);
            chk($sformatf("v%0d_count", v), fifo_count, 1);
            chk($sformatf("v%0d_busy", v), busy, 0);
            pop();
            chk($sformatf("v%0d_count_after_pop", v), fifo_count, 0);
            chk($sformatf("v%0d_valid_after_pop", v), rd_valid, 0);
            chk($sformatf("v%0d_data_hold", v), rd_data, vecs[v].exp_data);
        end

        // Clock glitch one sample short of the filter length
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        repeat (FL - 1) tick();
        ps2_clk = 1'b1;
        seen_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy) seen_busy = 1'b1;
        end
        ps2_data = 1'b1;
        $display("glitch: %0d-cycle low pulse, busy seen=%0b count=%0d", FL - 1, seen_busy, fifo_count);
        chk("glitch_busy", seen_busy, 0);
        chk("glitch_count", fifo_count, 0);

        // Watchdog: start + 4 data bits, then clock idles high
        ps2_bit(1'b0, lat);
        ps2_bit(1'b1, lat);
        ps2_bit(1'b0, lat);
        ps2_bit(1'b1, lat);
        ps2_bit(1'b1, lat);
        ps2_data = 1'b1;
        chk("wd_busy_before", busy, 1);
        pulses = 0;
        at_tick = -1;
        for (int i = 1; i <= TO + 200; i++) begin
            tick();
            if (timeout_p) begin
                pulses++;
                if (at_tick < 0) at_tick = i;
            end
        end
        $display("watchdog: pulses=%0d at tick %0d busy=%0b", pulses, at_tick, busy);
        chk("wd_pulses", pulses, 1);
        chk("wd_pulse_time", at_tick, 11 + TO - H);
        chk("wd_busy_after", busy, 0);
        chk("wd_count", fifo_count, 0);
        send_frame(8'hF0, 1'b0, 1'b1, lat);
        $display("after watchdog: sent F0 -> rd_data=%02h rd_err=%0b", rd_data, rd_err);
        chk("wd_next_data", rd_data, 8'hF0);
        chk("wd_next_err", rd_err, 0);
        chk("wd_next_count", fifo_count, 1);
        pop();

        // Overflow: 9 frames into an 8-deep FIFO with the consumer stalled
        for (int k = 1; k <= 9; k++) begin
            send_frame(8'(k), 1'b0, 1'b1, lat);
            $display("fill: sent %02h count=%0d overflow=%0b", k, fifo_count, overflow);
            if (k == 8) begin
                chk("ovf_count_at_8", fifo_count, 8);
                chk("ovf_flag_at_8", overflow, 0);
            end
        end
        chk("ovf_count_at_9", fifo_count, 8);
        chk("ovf_flag_at_9", overflow, 1);
        chk("ovf_head", rd_data, 8'h01);
        for (int k = 1; k <= 8; k++) begin
            $display("drain: rd_valid=%0b rd_data=%02h rd_err=%0b", rd_valid, rd_data, rd_err);
            chk($sformatf("drain%0d_valid", k), rd_valid, 1);
            chk($sformatf("drain%0d_data", k), rd_data, k);
            chk($sformatf("drain%0d_err", k), rd_err, 0);
            pop();
        end
        chk("drain_count", fifo_count, 0);
        chk("drain_valid", rd_valid, 0);
        chk("drain_ovf_sticky", overflow, 1);
        pop();
        chk("pop_empty_count", fifo_count, 0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", overflow, 0);

        // Reset after 5th data bit, with one byte already queued
        send_frame(8'h33, 1'b0, 1'b1, lat);
        chk("prerst_count", fifo_count, 1);
        ps2_bit(1'b0, lat);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1, lat);
        chk("prerst_busy", busy, 1);
        reset = 1'b1;
        #2;
        $display("reset mid-frame: rd_valid=%0b rd_data=%02h count=%0d busy=%0b",
                 rd_valid, rd_data, fifo_count, busy);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_p", timeout_p, 0);
        tick();
        tick();
        ps2_data = 1'b1;
        reset = 1'b0;
        repeat (5) tick();
        send_frame(8'h5A, 1'b0, 1'b1, lat);
        $display("after reset: sent 5A -> rd_data=%02h rd_err=%0b lat=%0d", rd_data, rd_err, lat);
        chk("postrst_latency", lat, LAT);
        chk("postrst_data", rd_data, 8'h5A);
        chk("postrst_err", rd_err, 0);
        chk("postrst_count", fifo_count, 1);
        pop();
        chk("postrst_count_pop", fifo_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
